// File: rtl/sim_cam_multi.sv
// Multi-entry simulation CAM: DEPTH key->session-ID entries, parallel lookup,
// and INSERT/DELETE updates with status, behind two independent valid/ready channels.
module sim_cam_multi #(
  parameter int KEY_W = 96,
  parameter int DATA_W = 14,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lup_req_valid,
  output logic                      lup_req_ready,
  input  logic [KEY_W:0]            lup_req_din,
  output logic                      lup_rsp_valid,
  input  logic                      lup_rsp_ready,
  output logic [DATA_W+1:0]         lup_rsp_dout,
  input  logic                      upd_req_valid,
  output logic                      upd_req_ready,
  input  logic [KEY_W+DATA_W+1:0]   upd_req_din,
  output logic                      upd_rsp_valid,
  input  logic                      upd_rsp_ready,
  output logic [DATA_W+2:0]         upd_rsp_dout,
  output logic                      cam_ready,
  output logic [CNT_W-1:0]          occupancy
);

  // Handshake rule on every channel: a transfer happens at a rising edge where
  // valid and ready are both high; a raised valid stays high, with dout frozen,
  // until that transfer occurs.

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {L_IDLE, L_CMP, L_RSP} lup_state_t;
  typedef enum logic [1:0] {U_IDLE, U_EXE, U_RSP} upd_state_t;

  lup_state_t lup_state_q;
  upd_state_t upd_state_q;

  logic [DEPTH-1:0]  ent_valid_q;
  logic [KEY_W-1:0]  ent_key_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [CNT_W-1:0]  occ_q;
  logic              cam_ready_q;

  logic              lup_req_ready_q;
  logic              lup_rsp_valid_q;
  logic [DATA_W+1:0] lup_rsp_dout_q;
  logic [KEY_W-1:0]  lup_key_q;
  logic              lup_src_q;

  logic              upd_req_ready_q;
  logic              upd_rsp_valid_q;
  logic [DATA_W+2:0] upd_rsp_dout_q;
  logic [KEY_W-1:0]  upd_key_q;
  logic [DATA_W-1:0] upd_sid_q;
  logic              upd_op_q;
  logic              upd_src_q;

  // Lookup compare: descending scan so the lowest matching index wins.
  logic              lup_hit;
  logic [DATA_W-1:0] lup_data;

  always_comb begin
    lup_hit  = 1'b0;
    lup_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && (ent_key_q[i] == lup_key_q)) begin
        lup_hit  = 1'b1;
        lup_data = ent_data_q[i];
      end
    end
  end

  logic              upd_hit;
  logic [IDX_W-1:0]  upd_hit_idx;
  logic [DATA_W-1:0] upd_hit_data;
  logic              upd_free;
  logic [IDX_W-1:0]  upd_free_idx;

  always_comb begin
    upd_hit      = 1'b0;
    upd_hit_idx  = '0;
    upd_hit_data = '0;
    upd_free     = 1'b0;
    upd_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && (ent_key_q[i] == upd_key_q)) begin
        upd_hit      = 1'b1;
        upd_hit_idx  = IDX_W'(i);
        upd_hit_data = ent_data_q[i];
      end
      if (!ent_valid_q[i]) begin
        upd_free     = 1'b1;
        upd_free_idx = IDX_W'(i);
      end
    end
  end

  // Update decision for the EXE cycle.
  logic              wr_en;
  logic              clr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              upd_ok_d;
  logic [DATA_W-1:0] upd_rsp_sid_d;
  logic [CNT_W-1:0]  occ_d;

  always_comb begin
    wr_en         = 1'b0;
    clr_en        = 1'b0;
    wr_idx        = '0;
    upd_ok_d      = 1'b0;
    upd_rsp_sid_d = upd_sid_q;
    occ_d         = occ_q;
    if (!upd_op_q) begin
      if (upd_hit) begin
        wr_en    = 1'b1;
        wr_idx   = upd_hit_idx;
        upd_ok_d = 1'b1;
      end else if (upd_free) begin
        wr_en    = 1'b1;
        wr_idx   = upd_free_idx;
        upd_ok_d = 1'b1;
        occ_d    = occ_q + CNT_W'(1);
      end
    end else begin
      upd_rsp_sid_d = '0;
      if (upd_hit) begin
        clr_en        = 1'b1;
        wr_idx        = upd_hit_idx;
        upd_ok_d      = 1'b1;
        upd_rsp_sid_d = upd_hit_data;
        occ_d         = occ_q - CNT_W'(1);
      end
    end
  end

  // Key/data storage needs no reset: the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (upd_state_q == U_EXE && wr_en) begin
      ent_key_q[wr_idx]  <= upd_key_q;
      ent_data_q[wr_idx] <= upd_sid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_valid_q <= '0;
      occ_q       <= '0;
      cam_ready_q <= 1'b0;
    end else begin
      cam_ready_q <= 1'b1;
      if (upd_state_q == U_EXE) begin
        if (wr_en)  ent_valid_q[wr_idx] <= 1'b1;
        if (clr_en) ent_valid_q[wr_idx] <= 1'b0;
        occ_q <= occ_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lup_state_q     <= L_IDLE;
      lup_req_ready_q <= 1'b0;
      lup_rsp_valid_q <= 1'b0;
      lup_rsp_dout_q  <= '0;
      lup_key_q       <= '0;
      lup_src_q       <= 1'b0;
    end else begin
      case (lup_state_q)
        L_IDLE: begin
          lup_req_ready_q <= 1'b1;
          if (lup_req_valid && lup_req_ready_q) begin
            lup_key_q       <= lup_req_din[KEY_W:1];
            lup_src_q       <= lup_req_din[0];
            lup_req_ready_q <= 1'b0;
            lup_state_q     <= L_CMP;
          end
        end
        L_CMP: begin
          lup_rsp_dout_q  <= {lup_hit, lup_data, lup_src_q};
          lup_rsp_valid_q <= 1'b1;
          lup_state_q     <= L_RSP;
        end
        L_RSP: begin
          if (lup_rsp_ready) begin
            lup_rsp_valid_q <= 1'b0;
            lup_req_ready_q <= 1'b1;
            lup_state_q     <= L_IDLE;
          end
        end
        default: lup_state_q <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_state_q     <= U_IDLE;
      upd_req_ready_q <= 1'b0;
      upd_rsp_valid_q <= 1'b0;
      upd_rsp_dout_q  <= '0;
      upd_key_q       <= '0;
      upd_sid_q       <= '0;
      upd_op_q        <= 1'b0;
      upd_src_q       <= 1'b0;
    end else begin
      case (upd_state_q)
        U_IDLE: begin
          upd_req_ready_q <= 1'b1;
          if (upd_req_valid && upd_req_ready_q) begin
            upd_key_q       <= upd_req_din[KEY_W+DATA_W+1:DATA_W+2];
            upd_sid_q       <= upd_req_din[DATA_W+1:2];
            upd_op_q        <= upd_req_din[1];
            upd_src_q       <= upd_req_din[0];
            upd_req_ready_q <= 1'b0;
            upd_state_q     <= U_EXE;
          end
        end
        U_EXE: begin
          upd_rsp_dout_q  <= {upd_ok_d, upd_rsp_sid_d, upd_op_q, upd_src_q};
          upd_rsp_valid_q <= 1'b1;
          upd_state_q     <= U_RSP;
        end
        U_RSP: begin
          if (upd_rsp_ready) begin
            upd_rsp_valid_q <= 1'b0;
            upd_req_ready_q <= 1'b1;
            upd_state_q     <= U_IDLE;
          end
        end
        default: upd_state_q <= U_IDLE;
      endcase
    end
  end

  assign lup_req_ready = lup_req_ready_q;
  assign lup_rsp_valid = lup_rsp_valid_q;
  assign lup_rsp_dout  = lup_rsp_dout_q;
  assign upd_req_ready = upd_req_ready_q;
  assign upd_rsp_valid = upd_rsp_valid_q;
  assign upd_rsp_dout  = upd_rsp_dout_q;
  assign cam_ready     = cam_ready_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_sim_cam_multi.sv
// Bench for sim_cam_multi: directed scenarios plus randomized traffic checked
// against a key->sid list model of the table.
module tb_sim_cam_multi;
  localparam int KEY_W = 96;
  localparam int DATA_W = 14;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    clk;
  logic                    rst_n;
  logic                    lup_req_valid;
  logic                    lup_req_ready;
  logic [KEY_W:0]          lup_req_din;
  logic                    lup_rsp_valid;
  logic                    lup_rsp_ready;
  logic [DATA_W+1:0]       lup_rsp_dout;
  logic                    upd_req_valid;
  logic                    upd_req_ready;
  logic [KEY_W+DATA_W+1:0] upd_req_din;
  logic                    upd_rsp_valid;
  logic                    upd_rsp_ready;
  logic [DATA_W+2:0]       upd_rsp_dout;
  logic                    cam_ready;
  logic [CNT_W-1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  sim_cam_multi dut (
    .clk(clk), .rst_n(rst_n),
    .lup_req_valid(lup_req_valid), .lup_req_ready(lup_req_ready), .lup_req_din(lup_req_din),
    .lup_rsp_valid(lup_rsp_valid), .lup_rsp_ready(lup_rsp_ready), .lup_rsp_dout(lup_rsp_dout),
    .upd_req_valid(upd_req_valid), .upd_req_ready(upd_req_ready), .upd_req_din(upd_req_din),
    .upd_rsp_valid(upd_rsp_valid), .upd_rsp_ready(upd_rsp_ready), .upd_rsp_dout(upd_rsp_dout),
    .cam_ready(cam_ready), .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [KEY_W-1:0]  k;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t m_q[$];

  logic [KEY_W-1:0] key_a = 96'hC0A80001_C0A80002_1F90_0050;
  logic [KEY_W-1:0] pool[12];

  function automatic int m_find(input logic [KEY_W-1:0] k);
    for (int i = 0; i < m_q.size(); i++) if (m_q[i].k == k) return i;
    return -1;
  endfunction

  function automatic logic [DATA_W+1:0] m_lookup(input logic [KEY_W-1:0] k, input bit src);
    int idx;
    idx = m_find(k);
    if (idx < 0) return {1'b0, {DATA_W{1'b0}}, src};
    return {1'b1, m_q[idx].d, src};
  endfunction

  function automatic logic [DATA_W+2:0] m_update(input logic [KEY_W-1:0] k,
      input logic [DATA_W-1:0] sid, input bit op, input bit src);
    int idx;
    ent_t e;
    logic [DATA_W-1:0] d;
    idx = m_find(k);
    if (!op) begin
      if (idx >= 0) begin
        m_q[idx].d = sid;
        return {1'b1, sid, 1'b0, src};
      end
      if (m_q.size() < DEPTH) begin
        e.k = k;
        e.d = sid;
        m_q.push_back(e);
        return {1'b1, sid, 1'b0, src};
      end
      return {1'b0, sid, 1'b0, src};
    end
    if (idx >= 0) begin
      d = m_q[idx].d;
      m_q.delete(idx);
      return {1'b1, d, 1'b1, src};
    end
    return {1'b0, {DATA_W{1'b0}}, 1'b1, src};
  endfunction

  function automatic logic [KEY_W-1:0] fill_key(input int i);
    logic [31:0] a;
    logic [15:0] p;
    a = 32'hC0A80100 + i;
    p = 16'd1000 + i[15:0];
    return {a, 32'h0A000001, p, 16'd80};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Returns lat = edges from the accept edge until rsp_valid is seen (-1 on timeout).
  task automatic lup_send(input logic [KEY_W-1:0] key, input bit src, input bit ack,
      output logic [DATA_W+1:0] dout, output int lat, output bit busy);
    int n;
    lat = -1;
    dout = '0;
    busy = 1'b0;
    n = 0;
    while (!lup_req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!lup_req_ready) return;
    lup_req_din = {key, src};
    lup_req_valid = 1'b1;
    @(posedge clk);
    #1;
    lup_req_valid = 1'b0;
    busy = !lup_req_ready;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (lup_rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    dout = lup_rsp_dout;
    if (ack) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic upd_send(input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] sid,
      input bit op, input bit src, output logic [DATA_W+2:0] dout, output int lat,
      output logic [CNT_W-1:0] occ);
    int n;
    lat = -1;
    dout = '0;
    occ = '0;
    n = 0;
    while (!upd_req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!upd_req_ready) return;
    upd_req_din = {key, sid, op, src};
    upd_req_valid = 1'b1;
    @(posedge clk);
    #1;
    upd_req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (upd_rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    dout = upd_rsp_dout;
    occ = occupancy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lup_req_ready, upd_req_ready, lup_rsp_valid, upd_rsp_valid, cam_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {lup_req_ready, upd_req_ready, lup_rsp_valid, upd_rsp_valid, cam_ready});
    end
    checks++;
    if (lup_rsp_dout !== '0 || upd_rsp_dout !== '0) begin
      errors++;
      $display("FAIL reset_dout: got lup=%h upd=%h want 0", lup_rsp_dout, upd_rsp_dout);
    end
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
    rst_n = 1'b1;
    m_q.delete();
    @(posedge clk);
    #1;
    checks++;
    if ({cam_ready, lup_req_ready, upd_req_ready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: got %b want 111", {cam_ready, lup_req_ready, upd_req_ready});
    end
  endtask

  task automatic test_lookup_miss();
    logic [DATA_W+1:0] d;
    int lat;
    bit busy;
    lup_send(96'h1, 1'b1, 1'b1, d, lat, busy);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL miss_latency: got %0d want 1", lat);
    end
    checks++;
    if (d !== {1'b0, 14'h0, 1'b1}) begin
      errors++;
      $display("FAIL miss_dout: got %h want %h", d, {1'b0, 14'h0, 1'b1});
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL miss_busy: got req_ready=1 after accept want 0");
    end
    checks++;
    if (occupancy !== '0 || cam_ready !== 1'b1) begin
      errors++;
      $display("FAIL miss_state: got occ=%0d cam_ready=%b want 0 1", occupancy, cam_ready);
    end
  endtask

  task automatic test_insert_hit();
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    int lat;
    bit busy;
    ue = m_update(key_a, 14'h7F8, 1'b0, 1'b0);
    upd_send(key_a, 14'h7F8, 1'b0, 1'b0, ud, lat, occ);
    checks++;
    if (lat !== 1 || ud !== ue || occ !== 1) begin
      errors++;
      $display("FAIL insert_a: got lat=%0d dout=%h occ=%0d want 1 %h 1", lat, ud, occ, ue);
    end
    le = m_lookup(key_a, 1'b1);
    lup_send(key_a, 1'b1, 1'b1, ld, lat, busy);
    checks++;
    if (ld !== le || ld !== {1'b1, 14'h7F8, 1'b1}) begin
      errors++;
      $display("FAIL lookup_a: got %h want %h", ld, le);
    end
  endtask

  task automatic test_fill_full();
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    int lat;
    bit busy;
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      ue = m_update(fill_key(i), DATA_W'(i), 1'b0, 1'b1);
      upd_send(fill_key(i), DATA_W'(i), 1'b0, 1'b1, ud, lat, occ);
      checks++;
      if (ud !== ue || occ !== CNT_W'(i)) begin
        errors++;
        $display("FAIL fill_%0d: got dout=%h occ=%0d want %h %0d", i, ud, occ, ue, i);
      end
    end
    ue = m_update(fill_key(9), 14'd9, 1'b0, 1'b0);
    upd_send(fill_key(9), 14'd9, 1'b0, 1'b0, ud, lat, occ);
    checks++;
    if (ud !== ue || ud[DATA_W+2] !== 1'b0 || occ !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL full_insert: got dout=%h occ=%0d want %h %0d", ud, occ, ue, DEPTH);
    end
    ue = m_update(fill_key(3), 14'h3FF, 1'b0, 1'b0);
    upd_send(fill_key(3), 14'h3FF, 1'b0, 1'b0, ud, lat, occ);
    checks++;
    if (ud !== ue || ud[DATA_W+2] !== 1'b1 || occ !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL overwrite_3: got dout=%h occ=%0d want %h %0d", ud, occ, ue, DEPTH);
    end
    le = m_lookup(fill_key(3), 1'b0);
    lup_send(fill_key(3), 1'b0, 1'b1, ld, lat, busy);
    checks++;
    if (ld !== le || ld[DATA_W:1] !== 14'h3FF) begin
      errors++;
      $display("FAIL lookup_3: got %h want %h", ld, le);
    end
  endtask

  task automatic test_delete();
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    int lat;
    bit busy;
    ue = m_update(fill_key(1), 14'h0, 1'b1, 1'b1);
    upd_send(fill_key(1), 14'h0, 1'b1, 1'b1, ud, lat, occ);
    checks++;
    if (ud !== ue || ud !== {1'b1, 14'd1, 1'b1, 1'b1} || occ !== CNT_W'(DEPTH - 1)) begin
      errors++;
      $display("FAIL delete_1: got dout=%h occ=%0d want %h %0d", ud, occ, ue, DEPTH - 1);
    end
    le = m_lookup(fill_key(1), 1'b1);
    lup_send(fill_key(1), 1'b1, 1'b1, ld, lat, busy);
    checks++;
    if (ld !== le || ld[DATA_W+1] !== 1'b0) begin
      errors++;
      $display("FAIL lookup_deleted: got %h want %h", ld, le);
    end
    ue = m_update(fill_key(20), 14'h123, 1'b0, 1'b0);
    upd_send(fill_key(20), 14'h123, 1'b0, 1'b0, ud, lat, occ);
    checks++;
    if (ud !== ue || occ !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL reuse_slot: got dout=%h occ=%0d want %h %0d", ud, occ, ue, DEPTH);
    end
    ue = m_update(fill_key(21), 14'h124, 1'b1, 1'b0);
    upd_send(fill_key(21), 14'h124, 1'b1, 1'b0, ud, lat, occ);
    checks++;
    if (ud !== ue || ud[DATA_W+2] !== 1'b0) begin
      errors++;
      $display("FAIL delete_miss: got %h want %h", ud, ue);
    end
  endtask

  task automatic test_stall();
    logic [DATA_W+1:0] ld, le;
    int lat;
    bit busy;
    le = m_lookup(fill_key(3), 1'b1);
    lup_rsp_ready = 1'b0;
    lup_send(fill_key(3), 1'b1, 1'b0, ld, lat, busy);
    checks++;
    if (ld !== le) begin
      errors++;
      $display("FAIL stall_dout: got %h want %h", ld, le);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (lup_rsp_valid !== 1'b1 || lup_rsp_dout !== le || lup_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b d=%h r=%b want 1 %h 0",
                 i, lup_rsp_valid, lup_rsp_dout, lup_req_ready, le);
      end
    end
    lup_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (lup_rsp_valid !== 1'b0 || lup_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b r=%b want 0 1", lup_rsp_valid, lup_req_ready);
    end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    int llat, ulat;
    bit busy;
    do_reset();
    ue = m_update(key_a, 14'h7F8, 1'b0, 1'b0);
    upd_send(key_a, 14'h7F8, 1'b0, 1'b0, ud, ulat, occ);
    le = m_lookup(key_a, 1'b1);
    ue = m_update(key_a, 14'h0, 1'b1, 1'b0);
    fork
      lup_send(key_a, 1'b1, 1'b1, ld, llat, busy);
      upd_send(key_a, 14'h0, 1'b1, 1'b0, ud, ulat, occ);
    join
    checks++;
    if (llat !== 1 || ulat !== 1 || ld !== le || ld[DATA_W+1] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_lookup: got lat=%0d/%0d dout=%h want 1/1 %h", llat, ulat, ld, le);
    end
    checks++;
    if (ud !== ue || occ !== '0) begin
      errors++;
      $display("FAIL same_cycle_delete: got dout=%h occ=%0d want %h 0", ud, occ, ue);
    end
    le = m_lookup(key_a, 1'b0);
    lup_send(key_a, 1'b0, 1'b1, ld, llat, busy);
    checks++;
    if (ld !== le || ld[DATA_W+1] !== 1'b0) begin
      errors++;
      $display("FAIL after_delete_lookup: got %h want %h", ld, le);
    end
  endtask

  task automatic test_reset_mid_update();
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    int lat;
    bit busy;
    bit saw_rsp;
    ue = m_update(key_a, 14'h11, 1'b0, 1'b0);
    upd_send(key_a, 14'h11, 1'b0, 1'b0, ud, lat, occ);
    checks++;
    if (occ !== 1) begin
      errors++;
      $display("FAIL pre_abort_occ: got %0d want 1", occ);
    end
    upd_req_din = {fill_key(5), 14'h55, 1'b0, 1'b0};
    upd_req_valid = 1'b1;
    @(posedge clk);
    #1;
    upd_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_q.delete();
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (upd_rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("FAIL abort_rsp: got upd_rsp_valid=1 want 0");
    end
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL abort_occ: got %0d want 0", occupancy);
    end
    le = m_lookup(key_a, 1'b1);
    lup_send(key_a, 1'b1, 1'b1, ld, lat, busy);
    checks++;
    if (ld !== le) begin
      errors++;
      $display("FAIL abort_table: got %h want %h", ld, le);
    end
  endtask

  task automatic test_random();
    logic [DATA_W+2:0] exp_u_q[$];
    logic [DATA_W+1:0] exp_l_q[$];
    logic [DATA_W+2:0] ud, ue;
    logic [DATA_W+1:0] ld, le;
    logic [CNT_W-1:0] occ;
    logic [KEY_W-1:0] k;
    logic [DATA_W-1:0] sid;
    int lat, sel;
    bit busy, src, op;
    for (int i = 0; i < 12; i++) pool[i] = {$urandom(), $urandom(), $urandom()};
    do_reset();
    for (int it = 0; it < 80; it++) begin
      k = pool[$urandom_range(0, 11)];
      src = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        exp_l_q.push_back(m_lookup(k, src));
        lup_send(k, src, 1'b1, ld, lat, busy);
        le = exp_l_q.pop_front();
        checks++;
        if (lat !== 1 || ld !== le) begin
          errors++;
          $display("FAIL rand_lookup_%0d: got lat=%0d dout=%h want 1 %h", it, lat, ld, le);
        end
      end else begin
        op = (sel >= 8);
        sid = DATA_W'($urandom_range(1, 16383));
        exp_u_q.push_back(m_update(k, sid, op, src));
        upd_send(k, sid, op, src, ud, lat, occ);
        ue = exp_u_q.pop_front();
        checks++;
        if (lat !== 1 || ud !== ue || occ !== CNT_W'(m_q.size())) begin
          errors++;
          $display("FAIL rand_update_%0d: got lat=%0d dout=%h occ=%0d want 1 %h %0d",
                   it, lat, ud, occ, ue, m_q.size());
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lup_req_valid = 1'b0;
    lup_req_din = '0;
    lup_rsp_ready = 1'b1;
    upd_req_valid = 1'b0;
    upd_req_din = '0;
    upd_rsp_ready = 1'b1;
    test_reset();
    test_lookup_miss();
    test_insert_hit();
    test_fill_full();
    test_delete();
    test_stall();
    test_same_cycle();
    test_reset_mid_update();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
